// File: rtl/axi4_lite_mem_slave.sv
// rtl/axi4_lite_mem_slave.sv - AXI4-lite slave memory with programmable read latency
//
// Word-array memory behind an AXI4-lite slave port. The read and write FSMs are
// independent. Each FSM allows one outstanding transaction. RESP is 1 bit wide:
// 0 means OKAY and 1 means ERR.
//
// Optional feature macro: AXI_MEM_ALIGN_CHECK_EN
//   When it is defined, an address whose low log2(DATA_W/8) bits are non-zero
//   returns ERR.
//   When it is undefined, those bits are ignored.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   AR_ADDR/AR_VALID/AR_PROT/AR_READY read address channel (PROT ignored)
//   R_DATA/R_RESP/R_VALID/R_READY     read data channel
//   AW_ADDR/AW_VALID/AW_PROT/AW_READY write address channel (PROT ignored)
//   W_DATA/W_STRB/W_VALID/W_READY     write data channel
//   B_RESP/B_VALID/B_READY            write response channel

module axi4_lite_mem_slave #(
    parameter int                ADDR_W       = 64,
    parameter int                DATA_W       = 64,
    parameter int                DEPTH_WORDS  = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 64'h8000_0000,
    parameter int                READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   AR_ADDR,
    input  logic                AR_VALID,
    input  logic [2:0]          AR_PROT,
    output logic                AR_READY,
    output logic [DATA_W-1:0]   R_DATA,
    output logic                R_RESP,
    output logic                R_VALID,
    input  logic                R_READY,
    input  logic [ADDR_W-1:0]   AW_ADDR,
    input  logic                AW_VALID,
    input  logic [2:0]          AW_PROT,
    output logic                AW_READY,
    input  logic [DATA_W-1:0]   W_DATA,
    input  logic [DATA_W/8-1:0] W_STRB,
    input  logic                W_VALID,
    output logic                W_READY,
    output logic                B_RESP,
    output logic                B_VALID,
    input  logic                B_READY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
    typedef enum logic       {WR_IDLE, WR_RESP}          wr_state_t;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Returns {err, word_index}. The index is meaningless when err is set.
    function automatic logic [IDX_W:0] decode_addr(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        logic              err;
        off = addr - BASE_ADDR;
        err = (addr < BASE_ADDR) || ((off >> SHIFT) >= ADDR_W'(DEPTH_WORDS));
`ifdef AXI_MEM_ALIGN_CHECK_EN
        err = err || (addr[SHIFT-1:0] != '0);
`endif
        return {err, off[SHIFT +: IDX_W]};
    endfunction

    logic unused_prot;
    assign unused_prot = ^{AR_PROT, AW_PROT};

    // ---------------- read side ----------------
    rd_state_t         rd_state_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [IDX_W-1:0]  rd_idx_q;
    logic              rd_err_q;
    logic              ar_ready_q;
    logic              r_valid_q;
    logic              r_resp_q;
    logic [DATA_W-1:0] r_data_q;
    logic [IDX_W:0]    ar_dec_d;

    assign ar_dec_d = decode_addr(AR_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_idx_q   <= '0;
            rd_err_q   <= 1'b0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_resp_q   <= 1'b0;
            r_data_q   <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (AR_VALID && ar_ready_q) begin
                        rd_err_q   <= ar_dec_d[IDX_W];
                        rd_idx_q   <= ar_dec_d[IDX_W-1:0];
                        rd_cnt_q   <= CNT_W'(READ_LATENCY - 1);
                        ar_ready_q <= 1'b0;
                        rd_state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_cnt_q == '0) begin
                        // Sampling with a non-blocking read means that a write
                        // committed on this same edge is not yet visible.
                        r_data_q   <= rd_err_q ? '0 : mem[rd_idx_q];
                        r_resp_q   <= rd_err_q;
                        r_valid_q  <= 1'b1;
                        rd_state_q <= RD_RESP;
                    end else begin
                        rd_cnt_q <= rd_cnt_q - 1'b1;
                    end
                end
                RD_RESP: begin
                    if (R_READY) begin
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                        rd_state_q <= RD_IDLE;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign AR_READY = ar_ready_q;
    assign R_VALID  = r_valid_q;
    assign R_RESP   = r_resp_q;
    assign R_DATA   = r_data_q;

    // ---------------- write side ----------------
    wr_state_t         wr_state_q;
    logic              aw_ready_q;
    logic              w_ready_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic              aw_err_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              b_valid_q;
    logic              b_resp_q;

    logic [IDX_W:0]    aw_dec_d;
    logic              aw_fire_d;
    logic              w_fire_d;
    logic              commit_d;
    logic              wr_err_d;
    logic [IDX_W-1:0]  wr_idx_d;
    logic [DATA_W-1:0] wr_data_d;
    logic [STRB_W-1:0] wr_strb_d;
    logic              mem_we_d;

    assign aw_dec_d = decode_addr(AW_ADDR);

    // A beat counts as captured when it was latched earlier (its READY is low)
    // or when it fires this cycle. Beats that fire this cycle bypass the latches,
    // so the commit happens on the same edge that captures the last beat.
    always_comb begin
        aw_fire_d = AW_VALID && aw_ready_q;
        w_fire_d  = W_VALID && w_ready_q;
        commit_d  = (wr_state_q == WR_IDLE) && (aw_fire_d || !aw_ready_q)
                    && (w_fire_d || !w_ready_q);
        wr_err_d  = aw_fire_d ? aw_dec_d[IDX_W]     : aw_err_q;
        wr_idx_d  = aw_fire_d ? aw_dec_d[IDX_W-1:0] : aw_idx_q;
        wr_data_d = w_fire_d  ? W_DATA              : w_data_q;
        wr_strb_d = w_fire_d  ? W_STRB              : w_strb_q;
        mem_we_d  = rst_n && commit_d && !wr_err_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            aw_idx_q   <= '0;
            aw_err_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= 1'b0;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (aw_fire_d) begin
                        aw_err_q   <= aw_dec_d[IDX_W];
                        aw_idx_q   <= aw_dec_d[IDX_W-1:0];
                        aw_ready_q <= 1'b0;
                    end
                    if (w_fire_d) begin
                        w_data_q  <= W_DATA;
                        w_strb_q  <= W_STRB;
                        w_ready_q <= 1'b0;
                    end
                    if (commit_d) begin
                        b_valid_q  <= 1'b1;
                        b_resp_q   <= wr_err_d;
                        wr_state_q <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (B_READY) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        wr_state_q <= WR_IDLE;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    // Memory contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb_d[b]) begin
                    mem[wr_idx_d][b*8 +: 8] <= wr_data_d[b*8 +: 8];
                end
            end
        end
    end

    assign AW_READY = aw_ready_q;
    assign W_READY  = w_ready_q;
    assign B_VALID  = b_valid_q;
    assign B_RESP   = b_resp_q;

endmodule
